// File: rtl/block_nest_checker_pkg.sv
// Shared types and constants for the begin/end nesting checker.
// Word-FSM states, ASCII keyword letters, debug tag codes and the case-fold helper.
package block_chk_pkg;

  typedef enum logic [3:0] {
    S_SEP, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
  } word_st_e;

  localparam logic [7:0] CH_SEP = 8'h20;
  localparam logic [7:0] CH_B   = 8'h62;
  localparam logic [7:0] CH_E   = 8'h65;
  localparam logic [7:0] CH_G   = 8'h67;
  localparam logic [7:0] CH_I   = 8'h69;
  localparam logic [7:0] CH_N   = 8'h6e;
  localparam logic [7:0] CH_D   = 8'h64;

  localparam logic [1:0] T_IDLE    = 2'd0;
  localparam logic [1:0] T_PARTIAL = 2'd1;
  localparam logic [1:0] T_KEYWORD = 2'd2;
  localparam logic [1:0] T_OTHER   = 2'd3;

  function automatic logic [7:0] fold_lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5a) ? (c | 8'h20) : c;
  endfunction

  function automatic logic [1:0] state_tag(input word_st_e st);
    case (st)
      S_SEP:            return T_IDLE;
      S_BEGIN, S_END:   return T_KEYWORD;
      S_OTHER:          return T_OTHER;
      default:          return T_PARTIAL;
    endcase
  endfunction

endpackage

// File: rtl/block_nest_checker_if.sv
// Character-stream in / check-status out bundle for the nesting checker.
interface block_nest_checker_if #(parameter int DEPTH_W = 4);
  logic               clr;
  logic               in_valid;
  logic [7:0]         in;
  logic               result;
  logic [DEPTH_W-1:0] depth;
  logic               err;
  logic [1:0]         t;

  modport master (output clr, in_valid, in, input result, depth, err, t);
  modport slave  (input clr, in_valid, in, output result, depth, err, t);
endinterface

// File: rtl/block_nest_checker_kw_matcher.sv
// Case fold plus word FSM; flags keyword completion and the undo of a tentative keyword.
// Hit/undo strobes are combinational from the current state and the incoming char.
module kw_matcher
  import block_chk_pkg::*;
#(
  parameter bit CASE_INSENS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       in_valid_i,
  input  logic [7:0] char_i,
  output logic       begin_hit_o,
  output logic       end_hit_o,
  output logic       undo_o,
  output logic       undo_begin_o,
  output logic [1:0] t_o
);

  word_st_e   st_q, st_d;
  logic [1:0] t_q;
  logic [7:0] c;
  logic       is_sep;

  always_comb begin
    c      = CASE_INSENS ? fold_lower(char_i) : char_i;
    is_sep = (char_i == CH_SEP);
    st_d   = S_OTHER;
    if (is_sep) begin
      st_d = S_SEP;
    end else begin
      case (st_q)
        S_SEP:   st_d = (c == CH_B) ? S_B : ((c == CH_E) ? S_E : S_OTHER);
        S_B:     st_d = (c == CH_E) ? S_BE    : S_OTHER;
        S_BE:    st_d = (c == CH_G) ? S_BEG   : S_OTHER;
        S_BEG:   st_d = (c == CH_I) ? S_BEGI  : S_OTHER;
        S_BEGI:  st_d = (c == CH_N) ? S_BEGIN : S_OTHER;
        S_E:     st_d = (c == CH_N) ? S_EN    : S_OTHER;
        S_EN:    st_d = (c == CH_D) ? S_END   : S_OTHER;
        default: st_d = S_OTHER;
      endcase
    end
  end

  // Only the last prefix state can reach a keyword state, so entry == completion.
  assign begin_hit_o  = in_valid_i && (st_d == S_BEGIN);
  assign end_hit_o    = in_valid_i && (st_d == S_END);
  assign undo_o       = in_valid_i && !is_sep && ((st_q == S_BEGIN) || (st_q == S_END));
  assign undo_begin_o = (st_q == S_BEGIN);
  assign t_o          = t_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= S_SEP;
      t_q  <= T_IDLE;
    end else if (clr_i) begin
      st_q <= S_SEP;
      t_q  <= T_IDLE;
    end else if (in_valid_i) begin
      st_q <= st_d;
      t_q  <= state_tag(st_d);
    end
  end

endmodule

// File: rtl/block_nest_checker.sv
// Tracks begin/end nesting depth (saturating) over a char stream with a sticky error flag.
// Outputs are decoded from registers only; a char accepted at an edge shows right after it.
module block_nest_checker
  import block_chk_pkg::*;
#(
  parameter int DEPTH_W     = 4,
  parameter bit CASE_INSENS = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  block_nest_checker_if.slave  bus
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);

  logic               begin_hit, end_hit, undo, undo_begin;
  logic               commit;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;

  kw_matcher #(.CASE_INSENS(CASE_INSENS)) u_kw (
    .clk          (clk),
    .rst_n        (reset),
    .clr_i        (bus.clr),
    .in_valid_i   (bus.in_valid),
    .char_i       (bus.in),
    .begin_hit_o  (begin_hit),
    .end_hit_o    (end_hit),
    .undo_o       (undo),
    .undo_begin_o (undo_begin),
    .t_o          (bus.t)
  );

  assign commit = bus.in_valid && (bus.in == CH_SEP);

  // pend only ever belongs to the keyword currently under tentative evaluation.
  always_comb begin
    depth_d = depth_q;
    pend_d  = pend_q;
    err_d   = err_q;
    if (bus.clr) begin
      depth_d = '0;
      pend_d  = 1'b0;
      err_d   = 1'b0;
    end else if (begin_hit) begin
      if (depth_q == DEPTH_MAX) pend_d = 1'b1;
      else                      depth_d = depth_q + ONE;
    end else if (end_hit) begin
      if (depth_q == '0) pend_d = 1'b1;
      else               depth_d = depth_q - ONE;
    end else if (undo) begin
      if (pend_q)          pend_d  = 1'b0;
      else if (undo_begin) depth_d = depth_q - ONE;
      else                 depth_d = depth_q + ONE;
    end else if (commit) begin
      err_d  = err_q | pend_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign bus.depth  = depth_q;
  assign bus.err    = err_q;
  assign bus.result = (depth_q == '0) && !err_q && !pend_q;

endmodule
